// File: rtl/mdu_ctrl_pkg.sv
// Shared MDU definitions: opcode encoding used by the decoder and the
// multiply/divide sequencer, plus default operation latencies.
package mdu_ctrl_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8
    } mdu_op_e;

    localparam int unsigned MULT_LAT_DEF = 5;
    localparam int unsigned DIV_LAT_DEF  = 10;

    // Opcodes 1..8 are real MDU instructions; 0 and 9..15 are treated as none.
    function automatic logic mdu_is_act(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd8);
    endfunction

    // Opcodes that launch a multi-cycle operation.
    function automatic logic mdu_is_start(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd4);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational mult/div datapath. Produces the {HI,LO} pair that will be
// committed once the latency counter expires. Divide by zero returns the
// current HI/LO so the later commit leaves the architectural state intact.
module mdu_arith
    import mdu_ctrl_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] cur_hi,
    input  logic [31:0] cur_lo,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo
);

    logic signed [63:0] s_prod;
    logic [63:0]        u_prod;
    logic [31:0]        div_b;
    logic [31:0]        abs_a;
    logic [31:0]        abs_b;
    logic [31:0]        u_quot;
    logic [31:0]        u_rem;
    logic [31:0]        m_quot;
    logic [31:0]        m_rem;
    logic [31:0]        s_quot;
    logic [31:0]        s_rem;
    logic               b_zero;

    // Products, quotients and remainders for every op; the final mux picks one.
    always_comb begin
        b_zero = (b == 32'd0);
        s_prod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        u_prod = {32'd0, a} * {32'd0, b};
        // A zero divisor is replaced by 1 so the dividers never see x/0;
        // that result is discarded by the hold rule below anyway.
        div_b  = b_zero ? 32'd1 : b;
        abs_a  = a[31] ? (~a + 32'd1) : a;
        abs_b  = b_zero ? 32'd1 : (b[31] ? (~b + 32'd1) : b);
        u_quot = a / div_b;
        u_rem  = a % div_b;
        // Signed divide on magnitudes; 0x80000000/-1 falls out as
        // quotient 0x80000000, remainder 0 with no special case.
        m_quot = abs_a / abs_b;
        m_rem  = abs_a % abs_b;
        s_quot = (a[31] ^ b[31]) ? (~m_quot + 32'd1) : m_quot;
        s_rem  = a[31] ? (~m_rem + 32'd1) : m_rem;

        res_hi = cur_hi;
        res_lo = cur_lo;
        case (op)
            MDU_MULT: begin
                res_hi = s_prod[63:32];
                res_lo = s_prod[31:0];
            end
            MDU_MULTU: begin
                res_hi = u_prod[63:32];
                res_lo = u_prod[31:0];
            end
            MDU_DIV: begin
                if (!b_zero) begin
                    res_hi = s_rem;
                    res_lo = s_quot;
                end
            end
            MDU_DIVU: begin
                if (!b_zero) begin
                    res_hi = u_rem;
                    res_lo = u_quot;
                end
            end
            default: begin
                res_hi = cur_hi;
                res_lo = cur_lo;
            end
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide sequencer. Owns HI/LO, models mult/div latency
// with a down-counter, and requests a pipeline stall when an MDU instruction
// arrives while an operation is in flight.
// Optional build macro MDU_CANCEL_EN adds a cancel input that discards an
// in-flight operation (exception flush).
//
// Handshake: an MDU instruction (en && op 1..8) is accepted on the rising
// edge of any cycle in which stall is low; while stall is high the pipeline
// holds the instruction and re-presents it, and this block takes no action.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int unsigned MULT_LAT = MULT_LAT_DEF,
    parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        reset,
`ifdef MDU_CANCEL_EN
    input  logic        cancel,
`endif
    input  logic        en,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        stall,
    output logic [31:0] rdata,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] MULT_CNT = 4'(MULT_LAT);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT);

    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic [3:0]  cnt_q, cnt_d;

    logic        act;
    logic        fire;
    logic        cancel_w;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

`ifdef MDU_CANCEL_EN
    assign cancel_w = cancel;
`else
    assign cancel_w = 1'b0;
`endif

    assign act   = en && mdu_is_act(mdu_op);
    assign busy  = (cnt_q != 4'd0);
    assign stall = act && busy;
    assign fire  = act && !stall;
    assign hi    = hi_q;
    assign lo    = lo_q;

    mdu_arith u_arith (
        .op     (mdu_op),
        .a      (a),
        .b      (b),
        .cur_hi (hi_q),
        .cur_lo (lo_q),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    // Move-from reads are purely combinational from the committed registers.
    always_comb begin
        rdata = 32'd0;
        case (mdu_op)
            MDU_MFHI: rdata = hi_q;
            MDU_MFLO: rdata = lo_q;
            default:  rdata = 32'd0;
        endcase
    end

    // Next state: count down, commit on the last busy cycle, launch or move on fire.
    always_comb begin
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        cnt_d     = cnt_q;

        if (cnt_q > 4'd1) begin
            cnt_d = cnt_q - 4'd1;
        end else if (cnt_q == 4'd1) begin
            cnt_d = 4'd0;
            hi_d  = pend_hi_q;
            lo_d  = pend_lo_q;
        end

        // fire implies !busy, so none of this can overlap a commit.
        if (fire) begin
            case (mdu_op)
                MDU_MULT, MDU_MULTU: begin
                    pend_hi_d = res_hi;
                    pend_lo_d = res_lo;
                    cnt_d     = MULT_CNT;
                end
                MDU_DIV, MDU_DIVU: begin
                    pend_hi_d = res_hi;
                    pend_lo_d = res_lo;
                    cnt_d     = DIV_CNT;
                end
                MDU_MTHI: hi_d = a;
                MDU_MTLO: lo_d = a;
                default: begin
                    cnt_d = cnt_q;
                end
            endcase
        end

        // Cancel drops both the pending commit and anything firing this cycle.
        if (cancel_w) begin
            cnt_d     = 4'd0;
            hi_d      = hi_q;
            lo_d      = lo_q;
            pend_hi_d = pend_hi_q;
            pend_lo_d = pend_lo_q;
        end
    end

    // State registers with synchronous reset; reset also aborts any op.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            cnt_q     <= 4'd0;
        end else begin
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: directed scenarios followed by random MDU traffic,
// checked against an arithmetic reference model and a cycle-level
// availability model (next cycle at which the unit is free).
module tb_mdu_ctrl;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic        clk;
    logic        reset;
    logic        en;
    logic [3:0]  mdu_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        stall;
    logic [31:0] rdata;
    logic [31:0] hi;
    logic [31:0] lo;
`ifdef MDU_CANCEL_EN
    logic        cancel;
`endif

    int n_tests;
    int n_fail;
    int cyc;

    // Reference state: architectural HI/LO after every accepted op, and
    // the first cycle index at which a new MDU op can be accepted.
    logic [31:0] model_hi;
    logic [31:0] model_lo;
    int          free_at;

    // Expected queue entry: {op[3:0], hi[31:0], lo[31:0], rdata[31:0]}.
    logic [99:0] exp_q[$];

    mdu_ctrl #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) dut (
        .clk    (clk),
        .reset  (reset),
`ifdef MDU_CANCEL_EN
        .cancel (cancel),
`endif
        .en     (en),
        .mdu_op (mdu_op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .stall  (stall),
        .rdata  (rdata),
        .hi     (hi),
        .lo     (lo)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Reference arithmetic from the instruction-set definition.
    task automatic model_apply(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        longint          sx, sy, sp, sq, sr;
        longint unsigned ux, uy, up;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (op)
            4'd1: begin
                sp = sx * sy;
                model_hi = sp[63:32];
                model_lo = sp[31:0];
            end
            4'd2: begin
                up = ux * uy;
                model_hi = up[63:32];
                model_lo = up[31:0];
            end
            4'd3: if (y != 0) begin
                sq = sx / sy;
                sr = sx % sy;
                model_hi = sr[31:0];
                model_lo = sq[31:0];
            end
            4'd4: if (y != 0) begin
                model_hi = x % y;
                model_lo = x / y;
            end
            4'd7: model_hi = x;
            4'd8: model_lo = x;
            default: ;
        endcase
    endtask

    // Scoreboard monitor: every accepted MDU instruction pops one entry.
    always @(negedge clk) begin
        logic [99:0] e;
        if (!reset && en && mdu_op >= 4'd1 && mdu_op <= 4'd8 && !stall) begin
            if (exp_q.size() == 0) begin
                check("unexpected_accept", {28'd0, mdu_op}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("accept_op",    {28'd0, mdu_op}, {28'd0, e[99:96]});
                check("accept_hi",    hi,    e[95:64]);
                check("accept_lo",    lo,    e[63:32]);
                check("accept_rdata", rdata, e[31:0]);
            end
        end
    end

    // Drive one MDU instruction and hold it until accepted; check stall length.
    task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        int   t;
        int   exp_st;
        int   n_st;
        bit   acc;
        logic [31:0] erd;
        t      = cyc;
        exp_st = (free_at > t) ? (free_at - t) : 0;
        erd    = (op == 4'd5) ? model_hi : ((op == 4'd6) ? model_lo : 32'd0);
        exp_q.push_back({op, model_hi, model_lo, erd});
        en = 1'b1; mdu_op = op; a = x; b = y;
        n_st = 0;
        acc  = 1'b0;
        for (int k = 0; k < 40 && !acc; k++) begin
            @(negedge clk);
            if (stall) n_st++;
            else acc = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            check("accept_timeout", 32'd0, 32'd1);
            if (exp_q.size() > 0) void'(exp_q.pop_back());
        end
        check("stall_cycles", 32'(n_st), 32'(exp_st));
        model_apply(op, x, y);
        if (op == 4'd1 || op == 4'd2) free_at = cyc + MULT_LAT;
        if (op == 4'd3 || op == 4'd4) free_at = cyc + DIV_LAT;
        en = 1'b0; mdu_op = 4'd0; a = $urandom; b = $urandom;
    endtask

    // One cycle with no MDU instruction; must never stall.
    task automatic idle(input logic e_in, input logic [3:0] op);
        en = e_in; mdu_op = op; a = $urandom; b = $urandom;
        @(negedge clk);
        check("idle_stall", {31'd0, stall}, 32'd0);
        check("idle_busy",  {31'd0, busy},  {31'd0, (free_at > cyc)});
        @(posedge clk);
        #1;
        en = 1'b0; mdu_op = 4'd0;
    endtask

    task automatic check_quiet(input string tag);
        @(negedge clk);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_hi"},   hi, model_hi);
        check({tag, "_lo"},   lo, model_lo);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1; en = 1'b0; mdu_op = 4'd0;
        repeat (cycles) @(posedge clk);
        #1;
        reset = 1'b0;
        model_hi = 32'd0;
        model_lo = 32'd0;
        free_at  = 0;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'(int'($urandom_range(0, 20)) - 10);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0;
        en = 1'b0; mdu_op = 4'd0; a = 32'd0; b = 32'd0; reset = 1'b1;
        model_hi = 32'd0; model_lo = 32'd0; free_at = 0;
`ifdef MDU_CANCEL_EN
        cancel = 1'b0;
`endif

        // Reset state
        do_reset(2);
        @(negedge clk);
        check("rst_hi",    hi,    32'd0);
        check("rst_lo",    lo,    32'd0);
        check("rst_busy",  {31'd0, busy},  32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        @(posedge clk);
        #1;

        // Signed mult followed immediately by mflo (5 stall cycles)
        issue(4'd1, 32'hFFFF_FFFD, 32'd5);
        issue(4'd6, 32'd0, 32'd0);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFF1);

        // Unsigned mult
        issue(4'd2, 32'hFFFF_FFFF, 32'd2);
        issue(4'd5, 32'd0, 32'd0);
        check("multu_hi", hi, 32'h0000_0001);
        check("multu_lo", lo, 32'hFFFF_FFFE);

        // Signed div, then divu by zero keeps HI/LO
        issue(4'd3, 32'hFFFF_FFF9, 32'd2);
        issue(4'd6, 32'd0, 32'd0);
        check("div_hi", hi, 32'hFFFF_FFFF);
        check("div_lo", lo, 32'hFFFF_FFFD);
        issue(4'd4, 32'd7, 32'd0);
        idle(1'b1, 4'd0);
        issue(4'd5, 32'd0, 32'd0);
        check("divz_hi", hi, 32'hFFFF_FFFF);
        check("divz_lo", lo, 32'hFFFF_FFFD);

        // Signed overflow case
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(4'd6, 32'd0, 32'd0);
        check("ovf_hi", hi, 32'd0);
        check("ovf_lo", lo, 32'h8000_0000);

        // mthi / mtlo, and a masked mthi with en=0
        issue(4'd7, 32'h1234_5678, 32'd0);
        check_quiet("mthi");
        check("mthi_hi", hi, 32'h1234_5678);
        issue(4'd8, 32'hCAFE_F00D, 32'd0);
        en = 1'b0; mdu_op = 4'd7; a = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        mdu_op = 4'd0;
        check_quiet("mthi_en0");

        // Non-MDU instructions while busy never stall
        issue(4'd4, 32'd1000, 32'd7);
        idle(1'b1, 4'd0);
        idle(1'b1, 4'd12);
        idle(1'b0, 4'd5);
        issue(4'd5, 32'd0, 32'd0);

        // Reset in the middle of a divide aborts it
        issue(4'd7, 32'h0000_00AA, 32'd0);
        issue(4'd3, 32'd100, 32'd7);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        do_reset(1);
        check_quiet("rst_mid");

`ifdef MDU_CANCEL_EN
        // Cancel in the middle of a divide keeps the pre-divide HI/LO
        issue(4'd7, 32'h0000_0055, 32'd0);
        issue(4'd8, 32'h0000_0066, 32'd0);
        issue(4'd3, 32'd100, 32'd7);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        cancel = 1'b1;
        model_hi = 32'h0000_0055;
        model_lo = 32'h0000_0066;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        free_at = 0;
        check_quiet("cancel");
`endif

        // Random traffic
        for (int i = 0; i < 80; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 7) issue(4'($urandom_range(1, 8)), pick_operand(), pick_operand());
            else if (r == 8) idle(1'b1, 4'd0);
            else idle(1'b1, 4'($urandom_range(9, 15)));
            repeat ($urandom_range(0, 2)) idle(1'($urandom_range(0, 1)), 4'd0);
        end
        issue(4'd5, 32'd0, 32'd0);
        issue(4'd6, 32'd0, 32'd0);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
Multiply/divide unit and its sequencer for the E stage of the 5-stage MIPS pipeline.
- Accepts the 4-bit MDU opcode produced by the decoder and owns the HI/LO registers.
- Models multi-cycle mult/div latency with a busy counter.
- Raises a stall request to the hazard logic whenever an MDU instruction in E must wait for an in-flight operation.

Parameters:
MULT_LAT, 5, cycles busy after a mult/multu start (1..15)
DIV_LAT, 10, cycles busy after a div/divu start (1..15)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
en  input  1  E-stage instruction valid (0 for bubble/flushed slot)
mdu_op  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9..15 treated as 0
a  input  32  forwarded rs value
b  input  32  forwarded rt value
busy  output  1  operation in flight (cnt != 0)
stall  output  1  stall request to hazard unit
rdata  output  32  HI when mdu_op=5, LO when mdu_op=6, else 0
hi  output  32  current HI register
lo  output  32  current LO register

Behaviour:
- State:
  - HI, LO (32b each).
  - pend_hi, pend_lo: result buffers (32b each).
  - cnt: 4-bit down-counter.
- Reset: HI=LO=pend_hi=pend_lo=0, cnt=0. Hence busy=0, stall=0, rdata=0 from the first cycle after reset.
- Reset mid-operation aborts the op; nothing is committed.
- Definitions:
  - act = en && mdu_op in 1..8.
  - stall = act && busy (combinational).
  - fire = act && !stall.
- Only a fired op has any effect. A stalled op is re-presented by the pipeline on later cycles.
- Start, on fire with op 1..4: pend ← result computed from a, b on that edge; cnt ← MULT_LAT (ops 1,2) or DIV_LAT (ops 3,4).
- Latency/commit:
  - While cnt>1: cnt decrements each cycle.
  - On the edge where cnt==1: cnt←0 and HI←pend_hi, LO←pend_lo.
  - busy is therefore high exactly LAT cycles after the start edge; results are visible in the same cycle busy falls.
- mthi/mtlo (fire, op 7/8): HI←a / LO←a on that edge. Cannot collide with a commit, because fire requires !busy.
- mfhi/mflo: rdata is combinational from the current HI/LO. It stalls while busy, so it never reads stale data.
- Arithmetic:
  - mult: signed 32×32→64; HI=[63:32], LO=[31:0].
  - multu: the unsigned equivalent.
  - div: LO=quotient truncated toward zero; HI=remainder, with the sign of the dividend.
  - divu: unsigned quotient and remainder.
- Divide by zero (b==0, op 3/4): still busy for DIV_LAT cycles; on commit HI/LO keep their old values (pend loaded with current HI/LO).
- Signed overflow 0x80000000/−1: LO=0x80000000, HI=0.
- Back-to-back ops: a second op 1..8 issued the cycle after a start stalls for LAT cycles, then fires on the cycle busy=0.
- Non-MDU instructions (mdu_op=0) never stall, even while busy.

Optional Feature:
MDU_CANCEL_EN:
- Defined: adds input port cancel (1b). When cancel=1 on an edge, cnt←0 and the pending commit is discarded (HI/LO unchanged). An op firing in the same cycle as cancel is also suppressed. Used for exception flush.
- Undefined: no cancel port; an in-flight op always commits.

Decomposition:
- Shared package holds:
  - the MDU opcode constants (MDU_NONE=0 … MDU_MTLO=8) used by both decoder and this block;
  - default latency constants MULT_LAT_DEF=5 and DIV_LAT_DEF=10.
- One natural sub-module, mdu_arith: purely combinational signed/unsigned mult/div producing {res_hi,res_lo}, including the div-by-zero hold rule. This block keeps the counter, HI/LO registers and stall logic.

Test Plan:
1. Reset high 2 cycles, then low → hi=lo=0, busy=0, stall=0, rdata=0.
2. mult a=0xFFFFFFFD b=5, then mflo presented next cycle:
   - stall=1 for 5 cycles;
   - hi=0xFFFFFFFF, lo=0xFFFFFFF1 when busy falls;
   - mflo fires that cycle with rdata=0xFFFFFFF1.
3. multu a=0xFFFFFFFF b=2 → after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
4. div a=0xFFFFFFF9 (−7) b=2 → busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. A following divu a=7 b=0 → busy 10 cycles, HI/LO unchanged.
5. mthi a=0x12345678 with no op in flight → hi=0x12345678 next cycle, stall=0. Same op presented with en=0 → no change. mdu_op=0 while busy → stall=0.
6. Start div, assert reset on cycle 4 → busy=0 next cycle and HI/LO=0. With MDU_CANCEL_EN: cancel on cycle 4 → busy=0, HI/LO keep pre-div values.
